// File: rtl/rv_pkg.sv
// Purpose: shared register-file writeback types and widths.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // One-hot of a destination register. x0 is never reported as pending.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    m[0]  = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Purpose: DEPTH-entry circular buffer holding long-latency writeback results.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (empties the buffer)
//   push, push_entry  enqueue request and payload
//   pop               dequeue request; head is the entry removed
//   head              oldest entry
//   full, empty,count occupancy status
//   ent_valid, ent_rd per-slot occupancy and destination, for the pending mask
module wb_fifo
  import rv_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  wb_entry_t                        push_entry,
  input  logic                             pop,
  output wb_entry_t                        head,
  output logic                             full,
  output logic                             empty,
  output logic [CW-1:0]                    count,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd
);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem[i].rd;
    end
  end

  // Payload storage carries no reset; ent_valid masks stale slots.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two. When a push and
  // a pop coincide the two slots differ (they only alias when empty or
  // full, and then one side is suppressed), so the valid updates never collide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (do_push) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Purpose: merges pipeline writeback and buffered long-latency results onto the register-file write port.
// Latency: pipeline result 1 cycle; long-latency result >=2 cycles via FIFO (1 cycle when bypassed).
// Backpressure: lsu_ready low when FIFO full or in reset; pipe_stall asserted when the FIFO has starved STARVE_LIMIT cycles.
//
// Optional feature macro: WB_BYPASS_EN -- an LSU result offered while the FIFO is
// empty and the pipeline is not writing goes straight to rf_* without queueing.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   pipe_valid/pipe_rd/pipe_data    in-order pipeline result (priority source)
//   pipe_stall                      pipeline result not consumed; upstream holds pipe_*
//   lsu_valid/lsu_ready             long-latency handshake
//   lsu_rd/lsu_data                 long-latency result
//   rf_we/rf_a3/rf_wd3              registered register-file write port
//   pend_mask                       registers with a queued, not-yet-written result
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  output logic                  pipe_stall,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]       rf_wd3,
  output logic [NUM_REGS-1:0]   pend_mask
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t                        fifo_head;
  wb_entry_t                        lsu_entry;
  wb_entry_t                        sel_entry;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [CW-1:0]                    fifo_count;
  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
  logic                             fifo_push;
  logic                             fifo_pop;
  logic                             pipe_req;
  logic                             pipe_win;
  logic                             bypass;
  logic                             sel_we;
  logic [SW-1:0]                    starve_cnt;

  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

  // x0 results are discarded at the door: they never win and never queue.
  assign pipe_req  = pipe_valid && (pipe_rd != '0);
  assign lsu_ready = rst_n && (fifo_count != CW'(DEPTH));

  // The counter only reaches the limit while the FIFO keeps losing to the
  // pipeline, so the stall fires exactly when the next pipeline win would
  // starve the head one cycle too many.
  assign pipe_stall = rst_n && (starve_cnt == SW'(STARVE_LIMIT)) && !fifo_empty && pipe_req;

  always_comb begin
    sel_we    = 1'b0;
    sel_entry = '0;
    fifo_pop  = 1'b0;
    pipe_win  = 1'b0;
    bypass    = 1'b0;
    if (rst_n) begin
      if (pipe_stall) begin
        sel_we    = 1'b1;
        sel_entry = fifo_head;
        fifo_pop  = 1'b1;
      end else if (pipe_req) begin
        sel_we    = 1'b1;
        sel_entry = '{rd: pipe_rd, data: pipe_data};
        pipe_win  = 1'b1;
      end else if (!fifo_empty) begin
        sel_we    = 1'b1;
        sel_entry = fifo_head;
        fifo_pop  = 1'b1;
      end else begin
`ifdef WB_BYPASS_EN
        // Empty FIFO means nothing older can be overtaken.
        if (lsu_valid && (lsu_rd != '0)) begin
          sel_we    = 1'b1;
          sel_entry = lsu_entry;
          bypass    = 1'b1;
        end
`endif
      end
    end
  end

  // A full FIFO refuses the push even when the head pops in the same cycle.
  assign fifo_push = lsu_valid && rst_n && !fifo_full && (lsu_rd != '0) && !bypass;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (lsu_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .ent_valid  (ent_valid),
    .ent_rd     (ent_rd)
  );

  // OR over live slots so duplicate destinations stay pending until the
  // last copy retires.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        pend_mask = pend_mask | rd_onehot(ent_rd[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fifo_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (pipe_win) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Address and data hold their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we  <= 1'b0;
      rf_a3  <= '0;
      rf_wd3 <= '0;
    end else begin
      rf_we <= sel_we;
      if (sel_we) begin
        rf_a3  <= sel_entry.rd;
        rf_wd3 <= sel_entry.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Purpose: directed bench for wb_arbiter with a write-order scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_arbiter;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [31:0] pend_mask;

  int checks = 0;
  int errors = 0;

  wb_entry_t exp_q[$];
  wb_entry_t mon_e;

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .pipe_stall (pipe_stall),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .rf_we      (rf_we),
    .rf_a3      (rf_a3),
    .rf_wd3     (rf_wd3),
    .pend_mask  (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    pipe_valid = pv;
    pipe_rd    = prd;
    pipe_data  = pd;
    lsu_valid  = lv;
    lsu_rd     = lrd;
    lsu_data   = ld;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    wb_entry_t e;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every register-file write must match the next expected one.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got a3=%0d wd3=0x%0h exp=no write", rf_a3, rf_wd3);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_a3 !== mon_e.rd || rf_wd3 !== mon_e.data) begin
          errors++;
          $display("FAIL wr_order got a3=%0d wd3=0x%0h exp a3=%0d wd3=0x%0h",
                   rf_a3, rf_wd3, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  initial begin
    int          n;
    logic        stall_exp;
    logic [31:0] m;

    // Reset, with traffic offered to prove it is refused.
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'h1111, 1'b1, 5'd3, 32'h2222);
    repeat (2) nxt();
    @(negedge clk);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_a3", rf_a3, 0);
    check("rst_rf_wd3", rf_wd3, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_lsu_ready", lsu_ready, 0);
    check("rst_pipe_stall", pipe_stall, 0);
    nxt();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("rel_lsu_ready", lsu_ready, 1);

    // 1: single pipeline write.
    nxt();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd5, 32'hDEADBEEF);
    nxt();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t1_we", rf_we, 1);
    check("t1_a3", rf_a3, 5);
    check("t1_wd3", rf_wd3, 32'hDEADBEEF);
    nxt();
    @(negedge clk);
    check("t1_we_idle", rf_we, 0);
    check("t1_a3_hold", rf_a3, 5);

    // 2: one long-latency result.
    nxt();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678);
    expect_wr(5'd7, 32'h12345678);
    @(negedge clk);
    check("t2_ready", lsu_ready, 1);
    nxt();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("t2_pend_c1", pend_mask, 0);
    check("t2_we_c1", rf_we, 1);
`else
    check("t2_pend_c1", pend_mask, 32'h80);
    check("t2_we_c1", rf_we, 0);
`endif
    nxt();
    @(negedge clk);
    check("t2_pend_c2", pend_mask, 0);
`ifdef WB_BYPASS_EN
    check("t2_we_c2", rf_we, 0);
`else
    check("t2_we_c2", rf_we, 1);
`endif

    // 3: fill while the pipeline writes x9 every cycle; starvation stalls
    //    fall on cycles 9 and 18, and a stalled pipe item is re-presented.
    n = 0;
    for (int c = 0; c < 20; c++) begin
      nxt();
      drive(1'b1, 5'd9, 32'h900 + 32'(n), (c <= 4), 5'(c + 1), 32'hA0 + 32'(c + 1));
      stall_exp = (c == 9) || (c == 18);
      if (c == 9)       expect_wr(5'd1, 32'hA1);
      else if (c == 18) expect_wr(5'd2, 32'hA2);
      else              expect_wr(5'd9, 32'h900 + 32'(n));
      @(negedge clk);
      check($sformatf("t3_stall_c%0d", c), pipe_stall, stall_exp);
      if (c <= 4)  check($sformatf("t3_ready_c%0d", c), lsu_ready, (c < 4));
      if (c == 4)  check("t3_pend_full", pend_mask, 32'h1E);
      if (c == 10) check("t3_pend_after1", pend_mask, 32'h1C);
      if (c == 19) check("t3_pend_after2", pend_mask, 32'h18);
      if (!stall_exp) n++;
    end
    nxt();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_wr(5'd3, 32'hA3);
    nxt();
    expect_wr(5'd4, 32'hA4);
    nxt();
    @(negedge clk);
    check("t3_pend_drained", pend_mask, 0);

    // 4: x0 from both sources together.
    nxt();
    drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    @(negedge clk);
    check("t4_ready", lsu_ready, 1);
    check("t4_stall", pipe_stall, 0);
    nxt();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t4_we", rf_we, 0);
    check("t4_pend", pend_mask, 0);

    // 5: hold two entries while pushing and popping every cycle (wraps twice).
    for (int c = 0; c < 10; c++) begin
      nxt();
      drive((c < 2), 5'd9, 32'hB00 + 32'(c), (c < 8), 5'(16 + c), 32'h100 + 32'(c));
      if (c < 2) expect_wr(5'd9, 32'hB00 + 32'(c));
      else       expect_wr(5'(16 + c - 2), 32'h100 + 32'(c - 2));
      @(negedge clk);
      if (c >= 2 && c <= 8) begin
        m = (32'h1 << (16 + c - 2)) | (32'h1 << (16 + c - 1));
        check($sformatf("t5_pend_c%0d", c), pend_mask, m);
      end
      if (c < 8) check($sformatf("t5_ready_c%0d", c), lsu_ready, 1);
    end

    // 6: reset with three entries queued; none may be written afterwards.
    for (int c = 0; c < 3; c++) begin
      nxt();
      drive(1'b1, 5'd9, 32'hC00 + 32'(c), 1'b1, 5'(11 + c), 32'hD0 + 32'(c));
      expect_wr(5'd9, 32'hC00 + 32'(c));
    end
    nxt();
    rst_n = 1'b0;
    drive(1'b1, 5'd9, 32'hC10, 1'b1, 5'd14, 32'hD9);
    @(negedge clk);
    check("t6_pend_queued", pend_mask, 32'h3800);
    check("t6_rst_ready", lsu_ready, 0);
    check("t6_rst_stall", pipe_stall, 0);
    nxt();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("t6_we", rf_we, 0);
    check("t6_pend", pend_mask, 0);
    check("t6_ready", lsu_ready, 1);
    repeat (4) nxt();
    @(negedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
